// File: rtl/decode_issue_ctrl.sv
// Decode issue controller: holds one fetched instruction, stalls it on scoreboard hazards, issues it downstream.
// Optional macro DECODE_STALL_COUNT_EN adds a saturating stall_count output.
module decode_issue_ctrl #(
    parameter int INSTRUCTION_LENGTH = 32,
    parameter int TYPE_WIDTH         = 3,
    parameter int FLAG_WIDTH         = 8,
    parameter int REGISTER_WIDTH     = 5
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [INSTRUCTION_LENGTH-1:0]   in_instruction,
    input  logic [TYPE_WIDTH-1:0]           in_type,
    input  logic [FLAG_WIDTH-1:0]           in_flag,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [INSTRUCTION_LENGTH-1:0]   out_instruction,
    output logic [TYPE_WIDTH-1:0]           out_type,
    output logic [FLAG_WIDTH-1:0]           out_flag,
    input  logic                            wb_valid,
    input  logic [REGISTER_WIDTH-1:0]       wb_rd,
    input  logic                            flush,
    output logic [2**REGISTER_WIDTH-1:0]    busy_mask
`ifdef DECODE_STALL_COUNT_EN
   ,output logic [15:0]                     stall_count
`endif
);

    localparam int NUM_REGS = 2**REGISTER_WIDTH;

    typedef enum logic {
        EMPTY = 1'b0,
        HELD  = 1'b1
    } state_t;

    state_t                          state_q, state_d;
    logic [INSTRUCTION_LENGTH-1:0]   instr_q, instr_d;
    logic [TYPE_WIDTH-1:0]           type_q, type_d;
    logic [FLAG_WIDTH-1:0]           flag_q, flag_d;
    logic [NUM_REGS-1:0]             busy_q, busy_d;

    logic [REGISTER_WIDTH-1:0]       rd;
    logic [REGISTER_WIDTH-1:0]       rs1;
    logic [REGISTER_WIDTH-1:0]       rs2;
    logic [NUM_REGS-1:0]             wb_onehot;
    logic [NUM_REGS-1:0]             pend;
    logic                            hazard;
    logic                            issue;
    logic                            accept;

    assign rd  = instr_q[7  +: REGISTER_WIDTH];
    assign rs1 = instr_q[15 +: REGISTER_WIDTH];
    assign rs2 = instr_q[20 +: REGISTER_WIDTH];

    // Writeback of register n makes n non-pending for this cycle's hazard check.
    always_comb begin
        wb_onehot = '0;
        if (wb_valid) begin
            wb_onehot[wb_rd] = 1'b1;
        end
    end

    assign pend = busy_q & ~wb_onehot;

    always_comb begin
        hazard = (flag_q[1] & pend[rs1]) |
                 (flag_q[2] & pend[rs2]) |
                 (flag_q[0] & pend[rd]);
    end

    assign out_valid = (state_q == HELD) & ~hazard & ~flush & ~reset;
    assign issue     = out_valid & out_ready;
    assign in_ready  = ((state_q == EMPTY) | issue) & ~flush & ~reset;
    assign accept    = in_valid & in_ready;

    assign out_instruction = instr_q;
    assign out_type        = type_q;
    assign out_flag        = flag_q;
    assign busy_mask       = busy_q;

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        type_d  = type_q;
        flag_d  = flag_q;
        if (flush) begin
            state_d = EMPTY;
        end else if (accept) begin
            state_d = HELD;
            instr_d = in_instruction;
            type_d  = in_type;
            flag_d  = in_flag;
        end else if (issue) begin
            state_d = EMPTY;
        end
    end

    // Writeback clear is applied before the issue set so a same-register set wins.
    always_comb begin
        busy_d = busy_q;
        if (flush) begin
            busy_d = '0;
        end else begin
            busy_d = busy_q & ~wb_onehot;
            if (issue && flag_q[0] && (rd != '0)) begin
                busy_d[rd] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            instr_q <= '0;
            type_q  <= '0;
            flag_q  <= '0;
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            type_q  <= type_d;
            flag_q  <= flag_d;
            busy_q  <= busy_d;
        end
    end

`ifdef DECODE_STALL_COUNT_EN
    logic [15:0] stall_q, stall_d;

    // Counts hazard stall cycles only; survives flush and saturates instead of wrapping.
    always_comb begin
        stall_d = stall_q;
        if ((state_q == HELD) && hazard && !flush && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Directed testbench for decode_issue_ctrl; drives inputs 1 time unit after each rising edge and checks before the next one.
module tb_decode_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instruction;
    logic [2:0]  in_type;
    logic [7:0]  in_flag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instruction;
    logic [2:0]  out_type;
    logic [7:0]  out_flag;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        flush;
    logic [31:0] busy_mask;
`ifdef DECODE_STALL_COUNT_EN
    logic [15:0] stall_count;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    decode_issue_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_instruction  (in_instruction),
        .in_type         (in_type),
        .in_flag         (in_flag),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instruction (out_instruction),
        .out_type        (out_type),
        .out_flag        (out_flag),
        .wb_valid        (wb_valid),
        .wb_rd           (wb_rd),
        .flush           (flush),
        .busy_mask       (busy_mask)
`ifdef DECODE_STALL_COUNT_EN
       ,.stall_count     (stall_count)
`endif
    );

    function automatic logic [31:0] mk_instr(input logic [4:0] rd, input logic [4:0] rs1,
                                             input logic [4:0] rs2, input logic [6:0] op);
        return {7'b0, rs2, rs1, 3'b000, rd, op};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid       = 1'b0;
        in_instruction = '0;
        in_type        = '0;
        in_flag        = '0;
        out_ready      = 1'b1;
        wb_valid       = 1'b0;
        wb_rd          = '0;
        flush          = 1'b0;
    endtask

    task automatic present(input logic [31:0] instr, input logic [2:0] typ, input logic [7:0] flg);
        in_valid       = 1'b1;
        in_instruction = instr;
        in_type        = typ;
        in_flag        = flg;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        present(mk_instr(5'd9, 5'd0, 5'd0, 7'h33), 3'd1, 8'h01);
        step();
        step();
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready);
        end
        idle_inputs();
        reset = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || busy_mask !== 32'h0 || out_instruction !== 32'h0 ||
            out_type !== 3'h0 || out_flag !== 8'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_state: got v=%b busy=%h ins=%h typ=%h flg=%h expected 0 0 0 0 0",
                     out_valid, busy_mask, out_instruction, out_type, out_flag);
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_release_ready: got %b expected 1", in_ready);
        end
`ifdef DECODE_STALL_COUNT_EN
        vectors++;
        if (stall_count !== 16'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_stall_count: got %0d expected 0", stall_count);
        end
`endif
        step();
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b;
        a = mk_instr(5'd1, 5'd2, 5'd3, 7'h33);
        b = mk_instr(5'd4, 5'd5, 5'd6, 7'h33);
        idle_inputs();
        present(a, 3'd0, 8'b0111);
        #1;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL b2b_empty: got rdy=%b v=%b expected 1 0", in_ready, out_valid);
        end
        step();
        present(b, 3'd0, 8'b0111);
        #1;
        vectors++;
        if (out_valid !== 1'b1 || out_instruction !== a || in_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL b2b_issue_a: got v=%b ins=%h rdy=%b expected 1 %h 1",
                     out_valid, out_instruction, in_ready, a);
        end
        step();
        in_valid = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b1 || out_instruction !== b || busy_mask !== 32'h2) begin
            miscompares++;
            $display("[TB] FAIL b2b_issue_b: got v=%b ins=%h busy=%h expected 1 %h 00000002",
                     out_valid, out_instruction, busy_mask, b);
        end
        step();
        vectors++;
        if (busy_mask !== 32'h12 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL b2b_busy: got busy=%h v=%b rdy=%b expected 00000012 0 1",
                     busy_mask, out_valid, in_ready);
        end
        wb_valid = 1'b1;
        wb_rd    = 5'd1;
        step();
        wb_rd = 5'd4;
        step();
        wb_valid = 1'b0;
        #1;
        vectors++;
        if (busy_mask !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL b2b_wb_clear: got %h expected 00000000", busy_mask);
        end
    endtask

    task automatic test_raw();
        logic [31:0] p, d;
        p = mk_instr(5'd5, 5'd0, 5'd0, 7'h33);
        d = mk_instr(5'd8, 5'd5, 5'd0, 7'h13);
        idle_inputs();
        present(p, 3'd0, 8'b0001);
        step();
        present(d, 3'd1, 8'b1011);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++;
            if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy_mask !== 32'h20) begin
                miscompares++;
                $display("[TB] FAIL raw_stall%0d: got v=%b rdy=%b busy=%h expected 0 0 00000020",
                         i, out_valid, in_ready, busy_mask);
            end
            step();
        end
        wb_valid = 1'b1;
        wb_rd    = 5'd5;
        #1;
        vectors++;
        if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_instruction !== d) begin
            miscompares++;
            $display("[TB] FAIL raw_bypass_issue: got v=%b rdy=%b ins=%h expected 1 1 %h",
                     out_valid, in_ready, out_instruction, d);
        end
        step();
        wb_valid = 1'b0;
        #1;
        vectors++;
        if (busy_mask !== 32'h100 || out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL raw_after: got busy=%h v=%b expected 00000100 0", busy_mask, out_valid);
        end
`ifdef DECODE_STALL_COUNT_EN
        vectors++;
        if (stall_count !== 16'd3) begin
            miscompares++;
            $display("[TB] FAIL raw_stall_count: got %0d expected 3", stall_count);
        end
`endif
        wb_valid = 1'b1;
        wb_rd    = 5'd8;
        step();
        wb_valid = 1'b0;
    endtask

    task automatic test_wb_issue_same();
        idle_inputs();
        present(mk_instr(5'd7, 5'd0, 5'd0, 7'h33), 3'd0, 8'b0001);
        step();
        present(mk_instr(5'd7, 5'd0, 5'd0, 7'h33), 3'd0, 8'b0001);
        step();
        in_valid = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || busy_mask !== 32'h80) begin
            miscompares++;
            $display("[TB] FAIL waw_stall: got v=%b busy=%h expected 0 00000080", out_valid, busy_mask);
        end
        wb_valid = 1'b1;
        wb_rd    = 5'd7;
        #1;
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL waw_bypass: got v=%b expected 1", out_valid);
        end
        step();
        wb_valid = 1'b0;
        #1;
        vectors++;
        if (busy_mask !== 32'h80 || out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL set_wins: got busy=%h v=%b expected 00000080 0", busy_mask, out_valid);
        end
        wb_valid = 1'b1;
        step();
        wb_valid = 1'b0;
    endtask

    task automatic test_x0();
        idle_inputs();
        present(mk_instr(5'd0, 5'd0, 5'd0, 7'h37), 3'd4, 8'b1001);
        step();
        present(mk_instr(5'd9, 5'd0, 5'd0, 7'h33), 3'd0, 8'b0111);
        #1;
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL x0_utype_issue: got v=%b expected 1", out_valid);
        end
        step();
        in_valid = 1'b0;
        wb_valid = 1'b1;
        wb_rd    = 5'd0;
        #1;
        vectors++;
        if (busy_mask !== 32'h0 || out_valid !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL x0_reader: got busy=%h v=%b expected 00000000 1", busy_mask, out_valid);
        end
        step();
        wb_valid = 1'b0;
        #1;
        vectors++;
        if (busy_mask !== 32'h200) begin
            miscompares++;
            $display("[TB] FAIL x0_after: got busy=%h expected 00000200", busy_mask);
        end
        wb_valid = 1'b1;
        wb_rd    = 5'd9;
        step();
        wb_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [31:0] h;
        h = mk_instr(5'd10, 5'd1, 5'd2, 7'h33);
        idle_inputs();
        present(h, 3'd2, 8'b0111);
        step();
        out_ready = 1'b0;
        present(mk_instr(5'd11, 5'd0, 5'd0, 7'h33), 3'd0, 8'b0001);
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_instruction !== h ||
                out_type !== 3'd2 || busy_mask !== 32'h0) begin
                miscompares++;
                $display("[TB] FAIL bp_hold%0d: got v=%b rdy=%b ins=%h typ=%h busy=%h expected 1 0 %h 2 00000000",
                         i, out_valid, in_ready, out_instruction, out_type, busy_mask, h);
            end
            step();
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        step();
        vectors++;
        if (busy_mask !== 32'h400 || out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL bp_release: got busy=%h v=%b expected 00000400 0", busy_mask, out_valid);
        end
        wb_valid = 1'b1;
        wb_rd    = 5'd10;
        step();
        wb_valid = 1'b0;
    endtask

    task automatic test_flush();
        idle_inputs();
        present(mk_instr(5'd1, 5'd0, 5'd0, 7'h33), 3'd0, 8'b0001);
        step();
        for (int r = 2; r < 32; r++) begin
            present(mk_instr(5'(r), 5'd0, 5'd0, 7'h33), 3'd0, 8'b0001);
            step();
        end
        present(mk_instr(5'd31, 5'd0, 5'd0, 7'h33), 3'd0, 8'b0001);
        step();
        in_valid = 1'b0;
        #1;
        vectors++;
        if (busy_mask !== 32'hFFFF_FFFE || out_valid !== 1'b0 || in_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL flush_setup: got busy=%h v=%b rdy=%b expected fffffffe 0 0",
                     busy_mask, out_valid, in_ready);
        end
        flush    = 1'b1;
        wb_valid = 1'b1;
        wb_rd    = 5'd31;
        present(mk_instr(5'd12, 5'd0, 5'd0, 7'h33), 3'd0, 8'b0001);
        #1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL flush_cycle: got v=%b rdy=%b expected 0 0", out_valid, in_ready);
        end
        step();
        idle_inputs();
        #1;
        vectors++;
        if (busy_mask !== 32'h0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL flush_after: got busy=%h v=%b rdy=%b expected 00000000 0 1",
                     busy_mask, out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_stall();
        idle_inputs();
        present(mk_instr(5'd3, 5'd0, 5'd0, 7'h33), 3'd0, 8'b0001);
        step();
        present(mk_instr(5'd4, 5'd3, 5'd0, 7'h13), 3'd1, 8'b0011);
        step();
        in_valid = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || busy_mask !== 32'h8) begin
            miscompares++;
            $display("[TB] FAIL rst_stall_setup: got v=%b busy=%h expected 0 00000008", out_valid, busy_mask);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        vectors++;
        if (busy_mask !== 32'h0 || out_valid !== 1'b0 || out_instruction !== 32'h0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL rst_mid_stall: got busy=%h v=%b ins=%h rdy=%b expected 00000000 0 00000000 1",
                     busy_mask, out_valid, out_instruction, in_ready);
        end
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        test_reset();
        test_back_to_back();
        test_raw();
        test_wb_issue_same();
        test_x0();
        test_backpressure();
        test_flush();
        test_reset_mid_stall();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
